// File: rtl/stack_alu_pkg.sv
// Shared opcodes, FSM state encoding and error codes for the stack ALU
// sequencer, plus the accept-time legality check.
package stack_alu_pkg;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_PUSHI = 4'd1;
    localparam logic [3:0] OP_DROP  = 4'd2;
    localparam logic [3:0] OP_DUP   = 4'd3;
    localparam logic [3:0] OP_ADD   = 4'd4;
    localparam logic [3:0] OP_SUB   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_OR    = 4'd7;
    localparam logic [3:0] OP_XOR   = 4'd8;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_UNDER = 2'd1;
    localparam logic [1:0] ERR_OVER  = 2'd2;
    localparam logic [1:0] ERR_ILL   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP_A,
        S_OP_B,
        S_PUSH,
        S_POP,
        S_DONE
    } state_t;

    function automatic logic is_binary(logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_XOR);
    endfunction

    function automatic logic is_push_op(logic [3:0] op);
        return (op == OP_PUSHI) || (op == OP_DUP);
    endfunction

    // Underflow takes priority over overflow (DUP on an empty stack).
    function automatic logic [1:0] check_cmd(
        logic [3:0]  op,
        int unsigned count,
        int unsigned depth
    );
        if (op > OP_XOR)
            return ERR_ILL;
        if (is_binary(op) && count < 2)
            return ERR_UNDER;
        if ((op == OP_DROP || op == OP_DUP) && count < 1)
            return ERR_UNDER;
        if (is_push_op(op) && count >= depth)
            return ERR_OVER;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/stack_alu_sequencer_if.sv
// Command handshake between the instruction source and the stack
// sequencer.
interface stack_alu_sequencer_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [15:0] cmd_imm;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_imm,
        output cmd_ready
    );

endinterface

// File: rtl/stack_alu.sv
// Combinational 16-bit stack ALU: y = b op a, where b is NOS and a is TOS.
// carry is bit 16 of the 17-bit sum or difference.
module stack_alu
    import stack_alu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y,
    output logic        zero,
    output logic        carry
);

    logic [16:0] full;

    always_comb begin
        full = {1'b0, b};
        case (op)
            OP_ADD:  full = {1'b0, b} + {1'b0, a};
            OP_SUB:  full = {1'b0, b} - {1'b0, a};
            OP_AND:  full = {1'b0, b & a};
            OP_OR:   full = {1'b0, b | a};
            OP_XOR:  full = {1'b0, b ^ a};
            default: full = {1'b0, b};
        endcase
    end

    assign y     = full[15:0];
    assign carry = full[16];
    assign zero  = (full[15:0] == 16'd0);

endmodule

// File: rtl/stack_alu_sequencer.sv
// Execute stage of the stack datapath: sequences LIFO push/pop strobes
// for one instruction at a time and reports result, flags and errors.
module stack_alu_sequencer
    import stack_alu_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int COUNT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    stack_alu_sequencer_if.slave cmd,
    input  logic [15:0]        stack_q,
    input  logic [COUNT_W-1:0] stack_count,
    output logic               stack_push,
    output logic               stack_pop,
    output logic [15:0]        stack_data,
    output logic               done,
    output logic [15:0]        result_q,
    output logic [1:0]         err_code,
    output logic               flag_z,
    output logic               flag_c
);

    state_t      state;
    state_t      next_acc;
    logic [3:0]  op_r;
    logic [15:0] imm_r;
    logic [15:0] a_r;
    logic [15:0] alu_y;
    logic        alu_z;
    logic        alu_c;
    logic [15:0] push_val;
    logic [1:0]  chk;
    logic [31:0] count_w;

    stack_alu u_alu (
        .op    (op_r),
        .a     (a_r),
        .b     (stack_q),
        .y     (alu_y),
        .zero  (alu_z),
        .carry (alu_c)
    );

    assign count_w  = 32'(stack_count);
    assign chk      = check_cmd(cmd.cmd_op, count_w, DEPTH);
    assign push_val = (op_r == OP_PUSHI) ? imm_r : a_r;

    // Errors retire straight away without touching the stack.
    always_comb begin
        next_acc = S_DONE;
        unique case (1'b1)
            (chk != ERR_OK):
                next_acc = S_DONE;
            (chk == ERR_OK && is_binary(cmd.cmd_op)):
                next_acc = S_POP_A;
            (chk == ERR_OK && is_push_op(cmd.cmd_op)):
                next_acc = S_PUSH;
            (chk == ERR_OK && cmd.cmd_op == OP_DROP):
                next_acc = S_POP;
            default:
                next_acc = S_DONE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_r     <= OP_NOP;
            imm_r    <= 16'd0;
            a_r      <= 16'd0;
            result_q <= 16'd0;
            err_code <= ERR_OK;
            flag_z   <= 1'b0;
            flag_c   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_r     <= cmd.cmd_op;
                        imm_r    <= cmd.cmd_imm;
                        a_r      <= stack_q;
                        err_code <= chk;
                        state    <= next_acc;
                    end
                end
                S_POP_A: state <= S_OP_B;
                S_OP_B: begin
                    result_q <= alu_y;
                    flag_z   <= alu_z;
                    flag_c   <= alu_c;
                    state    <= S_DONE;
                end
                S_PUSH: begin
                    result_q <= push_val;
                    state    <= S_DONE;
                end
                S_POP:   state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // OP_B is replace-top: stack_q holds NOS there, so data depends on it.
    assign cmd.cmd_ready = (state == S_IDLE);
    assign done          = (state == S_DONE);
    assign stack_push    = (state == S_PUSH) || (state == S_OP_B);
    assign stack_pop     = (state == S_POP_A) || (state == S_OP_B)
                        || (state == S_POP);

    always_comb begin
        stack_data = 16'd0;
        if (state == S_OP_B)
            stack_data = alu_y;
        else if (state == S_PUSH)
            stack_data = push_val;
    end

endmodule

// File: doc/stack_alu_sequencer.md
# stack_alu_sequencer

Command sequencer sitting directly upstream of the 16-bit hardware LIFO stack: it accepts one stack-machine instruction at a time, drives the stack's push/pop/data strobes and consumes its registered top-of-stack output. It executes binary ALU ops as replace-top (pop TOS, combine with NOS, overwrite NOS) and reports result, flags and error code. It forms the execute stage of the stack-based datapath.

## Interface
- DEPTH, 16, stack depth; must equal the attached LIFO's depth
- COUNT_W, 5, width of stack occupancy count (log2(DEPTH)+1)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command (high only in IDLE)
- cmd_op  in  4  opcode: 0 NOP, 1 PUSHI, 2 DROP, 3 DUP, 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR; 9–15 illegal
- cmd_imm  in  16  immediate for PUSHI
- stack_q  in  16  LIFO top-of-stack (registered, valid one cycle after any push/pop)
- stack_count  in  COUNT_W  LIFO occupancy
- stack_push  out  1  LIFO push strobe
- stack_pop  out  1  LIFO pop strobe
- stack_data  out  16  LIFO write data
- done  out  1  one-cycle pulse: command retired
- result_q  out  16  last pushed/computed value
- err_code  out  2  valid with done: 0 ok, 1 underflow, 2 overflow, 3 illegal
- flag_z  out  1  last ALU result == 0
- flag_c  out  1  ADD carry-out / SUB borrow

## Operation
- States: IDLE, POP_A, OP_B, PUSH, POP, DONE. Strobes decoded from registered state only.
- IDLE: cmd_ready=1. On cmd_valid: latch op, imm, a<=stack_q; check legality/occupancy; choose next state.
- Checks at accept: binary ops need count>=2, DROP/DUP need count>=1 else underflow; PUSHI/DUP need count<DEPTH else overflow; op>=9 illegal. Any error -> DONE directly, no strobes, stack untouched.
- Binary: IDLE -> POP_A (pop=1) -> OP_B (stack_q now NOS=b; push=1, pop=1, data=b op a) -> DONE. SUB computes b-a (NOS minus TOS); borrow in flag_c. AND/OR/XOR clear flag_c.
- PUSHI: IDLE -> PUSH (push=1, data=imm) -> DONE. DUP: same with data=a.
- DROP: IDLE -> POP (pop=1) -> DONE. NOP: IDLE -> DONE.
- DONE: done=1, err_code valid, result_q updated for PUSHI/DUP/ALU ops, flag_z/flag_c updated for ALU ops only (not on error); -> IDLE.
- Arithmetic 16-bit modulo; carry is bit 16 of 17-bit sum/difference.
- push and pop never asserted together except in OP_B (replace-top, occupancy unchanged).

## Timing
- Reset values: state IDLE, cmd_ready=1 after reset released, stack_push=0, stack_pop=0, stack_data=0, done=0, result_q=0, err_code=0, flag_z=0, flag_c=0.
- Latency accept->done: binary 3 cycles; PUSHI/DUP/DROP 2; NOP/error 1.
- Back-to-back: next command accepted the cycle after done; stack_q/stack_count already reflect prior op.
- Reset mid-operation: immediate return to IDLE, strobes drop same instant; reset must span >=1 clock edge so the LIFO also clears.
- cmd_* ignored while cmd_ready=0.

## Structure
- Package stack_alu_pkg: opcode constants, state encoding, err_code constants.
- One sub-module, stack_alu: combinational 16-bit op, result, zero, carry.
- Sequencer FSM, operand latch and output registers in the top.

## Test plan
- Reset, PUSHI 0x0005, PUSHI 0x0003, SUB -> push/pop strobes as specified, result_q=0x0002, stack_count=1, flag_c=0, err_code=0.
- PUSHI 0x0003, PUSHI 0x0005, SUB -> result 0xFFFE, flag_c=1; ADD 0xFFFF+0x0001 -> 0x0000, flag_z=1, flag_c=1.
- Empty stack, ADD -> done after 1 cycle, err_code=1, no strobes, flags unchanged.
- 16 PUSHI then DUP -> err_code=2, count stays 16; DROP -> count 15.
- cmd_op=12 -> err_code=3; NOP -> done next cycle, err_code=0.
- Assert reset during OP_B -> strobes 0 immediately, cmd_ready=1 after release, stack empty.
